plab5_mcore_mem_req_arb: RTL

Two-input, one-entry-buffered request arbiter that shares a core's single memory-network injection path between its instruction-fetch and data memory request streams. It sits between a core's icache/dcache request ports and the mem-request-to-network-message adapter. It grants round-robin, registers the winner, and presents the message with the `mode` (0 inst, 1 data) and `domain` tags the adapter consumes. An optional domain-switch fence is available (see Configuration).

---
 rtl/plab5_mcore_mem_req_arb_pkg.sv | 21 ++
 rtl/plab5_mcore_mem_req_arb_if.sv | 41 ++++
 rtl/plab5_mcore_mem_req_arb_rr_arb2.sv | 36 +++
 rtl/plab5_mcore_mem_req_arb.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/plab5_mcore_mem_req_arb_pkg.sv
// Shared types and constants for the core memory-request arbiter.
// Also provides the VC memory request message width macro when not already defined.
`ifndef VC_MEM_REQ_MSG_NBITS
`define VC_MEM_REQ_MSG_NBITS(o_,a_,d_) (3 + (o_) + (a_) + $clog2((d_)/8) + (d_))
`endif

package plab5_mcore_mem_req_arb_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_FENCE = 2'd2
    } arb_state_e;

    localparam logic MODE_INST = 1'b0;
    localparam logic MODE_DATA = 1'b1;

    // Message width for the default 8/32/32 opaque/address/data configuration
    localparam int C_MSG_NBITS_DFLT = `VC_MEM_REQ_MSG_NBITS(8, 32, 32);

endpackage

// File: rtl/plab5_mcore_mem_req_arb_if.sv
// Request/response bundle between the icache/dcache request ports, the arbiter
// and the network adapter. master = arbiter view, slave = surrounding logic view.
interface plab5_mcore_mem_req_arb_if
    import plab5_mcore_mem_req_arb_pkg::*;
#(
    parameter int p_msg_nbits = C_MSG_NBITS_DFLT
);
    logic                   inst_val;
    logic                   inst_rdy;
    logic [p_msg_nbits-1:0] inst_msg;
    logic                   inst_domain;

    logic                   data_val;
    logic                   data_rdy;
    logic [p_msg_nbits-1:0] data_msg;
    logic                   data_domain;

    logic                   out_val;
    logic                   out_rdy;
    logic [p_msg_nbits-1:0] out_msg;
    logic                   out_mode;
    logic                   out_domain;

    modport master (
        input  inst_val, inst_msg, inst_domain,
        output inst_rdy,
        input  data_val, data_msg, data_domain,
        output data_rdy,
        output out_val, out_msg, out_mode, out_domain,
        input  out_rdy
    );

    modport slave (
        output inst_val, inst_msg, inst_domain,
        input  inst_rdy,
        output data_val, data_msg, data_domain,
        input  data_rdy,
        input  out_val, out_msg, out_mode, out_domain,
        output out_rdy
    );
endinterface

// File: rtl/plab5_mcore_mem_req_arb_rr_arb2.sv
// Two-requester round-robin grant. Bit 0 / bit 1 requesters; the pointer
// moves to the non-granted requester whenever the caller takes the grant.
module plab5_mcore_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic [1:0] o_grant
);
    logic r_prio;

    // One-hot candidate: lone requester wins, ties go to the pointer
    always_comb begin
        o_grant = 2'b00;
        if (i_req == 2'b11) begin
            if (r_prio) begin
                o_grant = 2'b10;
            end else begin
                o_grant = 2'b01;
            end
        end else begin
            o_grant = i_req;
        end
    end

    // Priority pointer update on an accepted grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= 1'b0;
        end else if (i_take) begin
            r_prio <= o_grant[0];
        end else begin
            r_prio <= r_prio;
        end
    end
endmodule

// File: rtl/plab5_mcore_mem_req_arb.sv
// Round-robin inst/data memory request arbiter with a one-entry output buffer.
// Define PLAB5_MCORE_MEM_REQ_ARB_DOMAIN_FENCE_EN to insert idle cycles on a domain switch.
module plab5_mcore_mem_req_arb
    import plab5_mcore_mem_req_arb_pkg::*;
#(
    parameter int p_mem_opaque_nbits = 8,
    parameter int p_mem_addr_nbits   = 32,
    parameter int p_mem_data_nbits   = 32,
    parameter int p_fence_cycles     = 2
)(
    input  logic                       clk,
    input  logic                       reset,
    plab5_mcore_mem_req_arb_if.master  bus
);
    localparam int c_msg_nbits =
        `VC_MEM_REQ_MSG_NBITS(p_mem_opaque_nbits, p_mem_addr_nbits, p_mem_data_nbits);

    if (p_fence_cycles < 1) begin : g_fence_cycles_chk
        $error("p_fence_cycles must be at least 1");
    end

    logic [1:0]             w_cand;
    logic [1:0]             w_grant;
    logic                   w_accept_ok;
    logic                   w_block;
    logic                   w_take;
    logic [c_msg_nbits-1:0] w_load_msg;
    logic                   w_load_dom;

    arb_state_e             r_state;
    logic                   r_out_val;
    logic [c_msg_nbits-1:0] r_out_msg;
    logic                   r_out_mode;
    logic                   r_out_domain;

    plab5_mcore_rr_arb2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .i_req   ({bus.data_val, bus.inst_val}),
        .i_take  (w_take),
        .o_grant (w_cand)
    );

`ifdef PLAB5_MCORE_MEM_REQ_ARB_DOMAIN_FENCE_EN
    localparam int c_cnt_nbits = $clog2(p_fence_cycles + 1);
    localparam logic [c_cnt_nbits-1:0] c_fence_load = c_cnt_nbits'(p_fence_cycles);
    localparam logic [c_cnt_nbits-1:0] c_cnt_one    = c_cnt_nbits'(1);

    logic                   w_cand_dom;
    logic                   r_last_domain;
    logic [c_cnt_nbits-1:0] r_fence_cnt;

    // The fence judges the round-robin pick only; the other input is never promoted
    assign w_cand_dom = w_cand[1] ? bus.data_domain : bus.inst_domain;
    assign w_block    = (|w_cand) && (w_cand_dom != r_last_domain);

    // Fence countdown and domain of the most recent output transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fence_cnt   <= {c_cnt_nbits{1'b0}};
            r_last_domain <= 1'b0;
        end else if (r_state == ST_FENCE) begin
            if (r_fence_cnt <= c_cnt_one) begin
                r_fence_cnt   <= {c_cnt_nbits{1'b0}};
                r_last_domain <= (|w_cand) ? w_cand_dom : r_last_domain;
            end else begin
                r_fence_cnt   <= r_fence_cnt - c_cnt_one;
                r_last_domain <= r_last_domain;
            end
        end else begin
            r_fence_cnt   <= (w_block && w_accept_ok) ? c_fence_load : r_fence_cnt;
            r_last_domain <= (r_out_val && bus.out_rdy) ? r_out_domain : r_last_domain;
        end
    end
`else
    assign w_block = 1'b0;
`endif

    // Accept window: empty buffer, or full buffer draining this cycle
    always_comb begin
        w_accept_ok = 1'b0;
        if (reset) begin
            w_accept_ok = 1'b0;
        end else if (r_state == ST_EMPTY) begin
            w_accept_ok = 1'b1;
        end else if (r_state == ST_FULL) begin
            w_accept_ok = bus.out_rdy;
        end else begin
            w_accept_ok = 1'b0;
        end
        w_grant    = w_cand & {2{w_accept_ok & ~w_block}};
        w_take     = |w_grant;
        w_load_msg = w_grant[1] ? bus.data_msg : bus.inst_msg;
        w_load_dom = w_grant[1] ? bus.data_domain : bus.inst_domain;
    end

    assign bus.inst_rdy   = w_grant[0];
    assign bus.data_rdy   = w_grant[1];
    assign bus.out_val    = r_out_val;
    assign bus.out_msg    = r_out_msg;
    assign bus.out_mode   = r_out_mode;
    assign bus.out_domain = r_out_domain;

    // Buffer FSM with registered output message
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_EMPTY;
            r_out_val    <= 1'b0;
            r_out_msg    <= {c_msg_nbits{1'b0}};
            r_out_mode   <= MODE_INST;
            r_out_domain <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_take) begin
                        r_state      <= ST_FULL;
                        r_out_val    <= 1'b1;
                        r_out_msg    <= w_load_msg;
                        r_out_mode   <= w_grant[1] ? MODE_DATA : MODE_INST;
                        r_out_domain <= w_load_dom;
                    end else if (w_block) begin
                        r_state   <= ST_FENCE;
                        r_out_val <= 1'b0;
                    end else begin
                        r_state   <= ST_EMPTY;
                        r_out_val <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (!bus.out_rdy) begin
                        r_state   <= ST_FULL;
                        r_out_val <= 1'b1;
                    end else if (w_take) begin
                        r_state      <= ST_FULL;
                        r_out_val    <= 1'b1;
                        r_out_msg    <= w_load_msg;
                        r_out_mode   <= w_grant[1] ? MODE_DATA : MODE_INST;
                        r_out_domain <= w_load_dom;
                    end else if (w_block) begin
                        r_state   <= ST_FENCE;
                        r_out_val <= 1'b0;
                    end else begin
                        r_state   <= ST_EMPTY;
                        r_out_val <= 1'b0;
                    end
                end
                ST_FENCE: begin
                    r_out_val <= 1'b0;
`ifdef PLAB5_MCORE_MEM_REQ_ARB_DOMAIN_FENCE_EN
                    if (r_fence_cnt <= c_cnt_one) begin
                        r_state <= ST_EMPTY;
                    end else begin
                        r_state <= ST_FENCE;
                    end
`else
                    r_state <= ST_EMPTY;
`endif
                end
                default: begin
                    r_state   <= ST_EMPTY;
                    r_out_val <= 1'b0;
                end
            endcase
        end
    end
endmodule
